// File: rtl/mac_8bit_seq.sv
// Initiator-side sequencer for the 8-bit MAC: streams one dot-product job per command into the
// accumulator and returns the captured result. Optional result counter: define MAC_SEQ_RESCNT_EN.
module mac_8bit_seq #(
    parameter int COEF_DEPTH = 16,
    parameter int ADDR_W     = 4,
    parameter int LEN_W      = 5
) (
    input  logic              MAC_ACC_CLK,
    input  logic              acc_ff_rstn,
    input  logic              coef_we,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [7:0]        coef_wdata,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [5:0]        cmd_out_sel,
    input  logic              cmd_rnd,
    input  logic              cmd_sat,
    input  logic              cmd_tc,
    input  logic              smp_valid,
    output logic              smp_ready,
    input  logic [7:0]        smp_data,
    output logic [7:0]        MAC_OPER_DATA,
    output logic [7:0]        MAC_COEF_DATA,
    output logic              EFPGA_MATHB_CLK_EN,
    output logic              MAC_ACC_CLEAR,
    output logic              MAC_ACC_RND,
    output logic              MAC_ACC_SAT,
    output logic [5:0]        MAC_OUT_SEL,
    output logic              MAC_TC,
    input  logic [7:0]        MAC_OUT,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_data,
    output logic              busy
`ifdef MAC_SEQ_RESCNT_EN
   ,output logic [15:0]       res_count
`endif
);

    typedef enum logic [2:0] {IDLE, RUN, FLUSH, CAPT, DONE} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] len_clip;
    logic [5:0]       out_sel_q, out_sel_d;
    logic             rnd_q, rnd_d;
    logic             sat_q, sat_d;
    logic             tc_q, tc_d;
    logic [7:0]       oper_q, oper_d;
    logic [7:0]       coef_data_q, coef_data_d;
    logic             clk_en_q, clk_en_d;
    logic             clear_q, clear_d;
    logic             acc_rnd_q, acc_rnd_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       res_data_q, res_data_d;
    logic [7:0]       coef_q [COEF_DEPTH];
    logic [7:0]       coef_d [COEF_DEPTH];
    logic             first_tap;

    assign len_clip  = (cmd_len > LEN_W'(COEF_DEPTH)) ? LEN_W'(COEF_DEPTH) : cmd_len;
    assign first_tap = (idx_q == '0);

    // Reads see the pre-write contents, so a same-cycle write returns the old value.
    always_comb begin
        coef_d = coef_q;
        if (coef_we) begin
            coef_d[coef_addr] = coef_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        out_sel_d   = out_sel_q;
        rnd_d       = rnd_q;
        sat_d       = sat_q;
        tc_d        = tc_q;
        oper_d      = oper_q;
        coef_data_d = coef_data_q;
        clk_en_d    = 1'b0;
        clear_d     = 1'b0;
        acc_rnd_d   = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    out_sel_d = cmd_out_sel;
                    rnd_d     = cmd_rnd;
                    sat_d     = cmd_sat;
                    tc_d      = cmd_tc;
                    len_d     = len_clip;
                    idx_d     = '0;
                    if (cmd_len == '0) begin
                        res_data_d  = '0;
                        res_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (smp_valid) begin
                    oper_d      = smp_data;
                    coef_data_d = coef_q[idx_q[ADDR_W-1:0]];
                    clk_en_d    = 1'b1;
                    // First tap either clears the accumulator or preloads the rounding constant.
                    clear_d     = first_tap && !rnd_q;
                    acc_rnd_d   = first_tap && rnd_q;
                    idx_d       = idx_q + LEN_W'(1);
                    if (idx_q == len_q - LEN_W'(1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_d = CAPT;
            end
            CAPT: begin
                res_data_d  = MAC_OUT;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            out_sel_q   <= '0;
            rnd_q       <= 1'b0;
            sat_q       <= 1'b0;
            tc_q        <= 1'b0;
            oper_q      <= '0;
            coef_data_q <= '0;
            clk_en_q    <= 1'b0;
            clear_q     <= 1'b0;
            acc_rnd_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            for (int unsigned i = 0; i < COEF_DEPTH; i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            out_sel_q   <= out_sel_d;
            rnd_q       <= rnd_d;
            sat_q       <= sat_d;
            tc_q        <= tc_d;
            oper_q      <= oper_d;
            coef_data_q <= coef_data_d;
            clk_en_q    <= clk_en_d;
            clear_q     <= clear_d;
            acc_rnd_q   <= acc_rnd_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            coef_q      <= coef_d;
        end
    end

`ifdef MAC_SEQ_RESCNT_EN
    logic [15:0] res_count_q, res_count_d;

    always_comb begin
        res_count_d = res_count_q;
        if (res_valid_q && res_ready) begin
            res_count_d = res_count_q + 16'd1;
        end
    end

    always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn) begin
            res_count_q <= '0;
        end else begin
            res_count_q <= res_count_d;
        end
    end

    assign res_count = res_count_q;
`endif

    assign cmd_ready          = (state_q == IDLE);
    assign smp_ready          = (state_q == RUN);
    assign busy               = (state_q != IDLE);
    assign MAC_OPER_DATA      = oper_q;
    assign MAC_COEF_DATA      = coef_data_q;
    assign EFPGA_MATHB_CLK_EN = clk_en_q;
    assign MAC_ACC_CLEAR      = clear_q;
    assign MAC_ACC_RND        = acc_rnd_q;
    assign MAC_ACC_SAT        = sat_q;
    assign MAC_OUT_SEL        = out_sel_q;
    assign MAC_TC             = tc_q;
    assign res_valid          = res_valid_q;
    assign res_data           = res_data_q;

endmodule

// File: tb/tb_mac_8bit_seq.sv
// Directed bench for mac_8bit_seq with a behavioural MAC accumulator attached to its drive outputs.
module tb_mac_8bit_seq;

    logic        MAC_ACC_CLK = 1'b0;
    logic        acc_ff_rstn = 1'b1;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [7:0]  coef_wdata = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  cmd_len = '0;
    logic [5:0]  cmd_out_sel = '0;
    logic        cmd_rnd = 1'b0;
    logic        cmd_sat = 1'b0;
    logic        cmd_tc = 1'b0;
    logic        smp_valid = 1'b0;
    logic        smp_ready;
    logic [7:0]  smp_data = '0;
    logic [7:0]  MAC_OPER_DATA;
    logic [7:0]  MAC_COEF_DATA;
    logic        EFPGA_MATHB_CLK_EN;
    logic        MAC_ACC_CLEAR;
    logic        MAC_ACC_RND;
    logic        MAC_ACC_SAT;
    logic [5:0]  MAC_OUT_SEL;
    logic        MAC_TC;
    logic [7:0]  MAC_OUT;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_data;
    logic        busy;
`ifdef MAC_SEQ_RESCNT_EN
    logic [15:0] res_count;
`endif

    int          tests_run = 0;
    int          fails = 0;
    int          edges = 0;
    logic [7:0]  smp_mem [32];
    logic [31:0] vpat = '0;
    int          vpat_len = 0;

    mac_8bit_seq #(.COEF_DEPTH(16), .ADDR_W(4), .LEN_W(5)) dut (
        .MAC_ACC_CLK        (MAC_ACC_CLK),
        .acc_ff_rstn        (acc_ff_rstn),
        .coef_we            (coef_we),
        .coef_addr          (coef_addr),
        .coef_wdata         (coef_wdata),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_len            (cmd_len),
        .cmd_out_sel        (cmd_out_sel),
        .cmd_rnd            (cmd_rnd),
        .cmd_sat            (cmd_sat),
        .cmd_tc             (cmd_tc),
        .smp_valid          (smp_valid),
        .smp_ready          (smp_ready),
        .smp_data           (smp_data),
        .MAC_OPER_DATA      (MAC_OPER_DATA),
        .MAC_COEF_DATA      (MAC_COEF_DATA),
        .EFPGA_MATHB_CLK_EN (EFPGA_MATHB_CLK_EN),
        .MAC_ACC_CLEAR      (MAC_ACC_CLEAR),
        .MAC_ACC_RND        (MAC_ACC_RND),
        .MAC_ACC_SAT        (MAC_ACC_SAT),
        .MAC_OUT_SEL        (MAC_OUT_SEL),
        .MAC_TC             (MAC_TC),
        .MAC_OUT            (MAC_OUT),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_data           (res_data),
        .busy               (busy)
`ifdef MAC_SEQ_RESCNT_EN
       ,.res_count          (res_count)
`endif
    );

    always #5 MAC_ACC_CLK = ~MAC_ACC_CLK;
    always @(posedge MAC_ACC_CLK) edges++;

    // Behavioural MAC: accumulator with clear / round preload, shift by out_sel, optional saturation.
    logic signed [31:0] acc, prod, rconst, shv;
    always_comb begin
        if (MAC_TC) prod = {{24{MAC_OPER_DATA[7]}}, MAC_OPER_DATA} * {{24{MAC_COEF_DATA[7]}}, MAC_COEF_DATA};
        else        prod = {24'd0, MAC_OPER_DATA} * {24'd0, MAC_COEF_DATA};
        rconst = (MAC_OUT_SEL == 6'd0) ? 32'sd0 : (32'sd1 <<< (MAC_OUT_SEL - 6'd1));
        shv    = MAC_TC ? (acc >>> MAC_OUT_SEL) : (acc >> MAC_OUT_SEL);
        if (!MAC_ACC_SAT)  MAC_OUT = shv[7:0];
        else if (MAC_TC)   MAC_OUT = (shv > 32'sd127) ? 8'h7F : ((shv < -32'sd128) ? 8'h80 : shv[7:0]);
        else               MAC_OUT = ($unsigned(shv) > 32'd255) ? 8'hFF : shv[7:0];
    end
    always @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn)            acc <= '0;
        else if (EFPGA_MATHB_CLK_EN) acc <= (MAC_ACC_CLEAR ? 32'sd0 : (MAC_ACC_RND ? rconst : acc)) + prod;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [7:0] d);
        coef_we = 1'b1; coef_addr = a; coef_wdata = d;
        @(negedge MAC_ACC_CLK);
        coef_we = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ":busy"}, {31'd0, busy}, 32'd0);
        check({tag, ":mac"}, {5'd0, MAC_OPER_DATA, MAC_COEF_DATA, EFPGA_MATHB_CLK_EN, MAC_ACC_CLEAR,
                              MAC_ACC_RND, MAC_ACC_SAT, MAC_OUT_SEL, MAC_TC}, 32'd0);
        check({tag, ":res"}, {23'd0, res_valid, res_data}, 32'd0);
    endtask

    task automatic run_job(input logic [4:0] len, input logic [5:0] osel, input logic rnd,
                           input logic sat, input logic tc, input int hold,
                           input logic [7:0] exp_res, input int exp_hs, input string tag);
        int hs = 0, pi = 0, last_hs_edge = -100, rv_edge = -1;
        int en_err = 0, rnd_cnt = 0, clr_cnt = 0, ctrl_err = 0, bp_err = 0;
        logic v, hs_now;
        logic [7:0] held;
        cmd_len = len; cmd_out_sel = osel; cmd_rnd = rnd; cmd_sat = sat; cmd_tc = tc; cmd_valid = 1'b1;
        check({tag, ":cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        @(negedge MAC_ACC_CLK);
        cmd_valid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (res_valid) begin
                rv_edge = edges;
                break;
            end
            v = (vpat_len == 0) ? 1'b1 : ((pi < vpat_len) ? vpat[pi] : 1'b1);
            smp_valid = v;
            smp_data  = smp_mem[hs];
            hs_now    = v && smp_ready;
            if (hs_now) begin
                hs++;
                last_hs_edge = edges + 1;
            end
            pi++;
            @(negedge MAC_ACC_CLK);
            if (EFPGA_MATHB_CLK_EN !== hs_now) en_err++;
            if (MAC_ACC_RND === 1'b1) rnd_cnt++;
            if (MAC_ACC_CLEAR === 1'b1) clr_cnt++;
            if (MAC_TC !== tc || MAC_ACC_SAT !== sat || MAC_OUT_SEL !== osel) ctrl_err++;
        end
        smp_valid = 1'b0;
        check({tag, ":res_valid"}, {31'd0, res_valid}, 32'd1);
        check({tag, ":res_data"}, {24'd0, res_data}, {24'd0, exp_res});
        check({tag, ":samples"}, hs, exp_hs);
        check({tag, ":clk_en"}, en_err, 0);
        check({tag, ":rnd_pulses"}, rnd_cnt, (rnd && exp_hs > 0) ? 1 : 0);
        check({tag, ":clr_pulses"}, clr_cnt, (!rnd && exp_hs > 0) ? 1 : 0);
        check({tag, ":ctrl"}, ctrl_err, 0);
        if (exp_hs > 0) check({tag, ":latency"}, rv_edge - last_hs_edge, 2);
        held = res_data;
        for (int c = 0; c < hold; c++) begin
            @(negedge MAC_ACC_CLK);
            if (res_data !== held || res_valid !== 1'b1 || cmd_ready !== 1'b0 || smp_ready !== 1'b0) bp_err++;
        end
        check({tag, ":hold"}, bp_err, 0);
        res_ready = 1'b1;
        @(negedge MAC_ACC_CLK);
        res_ready = 1'b0;
        check({tag, ":after_hs"}, {30'd0, res_valid, busy}, 32'd0);
    endtask

    initial begin
        #3 acc_ff_rstn = 1'b0;
        #1 check_reset_state("por");
        @(negedge MAC_ACC_CLK);
        acc_ff_rstn = 1'b1;
        @(negedge MAC_ACC_CLK);

        write_coef(4'd0, 8'd1); write_coef(4'd1, 8'd2); write_coef(4'd2, 8'd3); write_coef(4'd3, 8'd4);
        smp_mem[0] = 8'd10; smp_mem[1] = 8'd20; smp_mem[2] = 8'd30; smp_mem[3] = 8'd40;
        run_job(5'd4, 6'd0, 1'b0, 1'b0, 1'b0, 1, 8'h2C, 4, "unsigned");
        run_job(5'd4, 6'd0, 1'b0, 1'b1, 1'b0, 1, 8'hFF, 4, "sat");
        vpat = 32'b1101001; vpat_len = 7;
        run_job(5'd4, 6'd0, 1'b0, 1'b0, 1'b0, 1, 8'h2C, 4, "stall");
        vpat_len = 0;

        write_coef(4'd0, 8'd1); write_coef(4'd1, 8'd1);
        smp_mem[0] = 8'd1; smp_mem[1] = 8'd2;
        run_job(5'd2, 6'd1, 1'b1, 1'b0, 1'b0, 1, 8'h02, 2, "rnd1");
        run_job(5'd2, 6'd1, 1'b0, 1'b0, 1'b0, 1, 8'h01, 2, "rnd0");

        write_coef(4'd0, 8'hFF);
        smp_mem[0] = 8'h05;
        run_job(5'd1, 6'd0, 1'b0, 1'b1, 1'b1, 1, 8'hFB, 1, "signed");

        run_job(5'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1, 8'h00, 0, "len0");

        for (int i = 0; i < 16; i++) write_coef(4'(i), 8'd1);
        for (int i = 0; i < 32; i++) smp_mem[i] = 8'd1;
        run_job(5'd20, 6'd0, 1'b0, 1'b0, 1'b0, 1, 8'h10, 16, "len20");

        // Abort a job after its second sample.
        cmd_len = 5'd4; cmd_out_sel = '0; cmd_rnd = 1'b0; cmd_sat = 1'b0; cmd_tc = 1'b0; cmd_valid = 1'b1;
        @(negedge MAC_ACC_CLK);
        cmd_valid = 1'b0; smp_valid = 1'b1; smp_data = 8'd10;
        @(negedge MAC_ACC_CLK);
        smp_data = 8'd20;
        @(negedge MAC_ACC_CLK);
        smp_valid = 1'b0;
        check("midjob:busy", {31'd0, busy}, 32'd1);
        acc_ff_rstn = 1'b0;
        #1 check_reset_state("midrst");
        @(negedge MAC_ACC_CLK);
        acc_ff_rstn = 1'b1;
        @(negedge MAC_ACC_CLK);

        smp_mem[0] = 8'd7;
        run_job(5'd1, 6'd0, 1'b0, 1'b0, 1'b0, 1, 8'h00, 1, "bank_clr");
        write_coef(4'd0, 8'd1); write_coef(4'd1, 8'd2); write_coef(4'd2, 8'd3); write_coef(4'd3, 8'd4);
        smp_mem[0] = 8'd10; smp_mem[1] = 8'd20; smp_mem[2] = 8'd30; smp_mem[3] = 8'd40;
        run_job(5'd4, 6'd0, 1'b0, 1'b0, 1'b0, 1, 8'h2C, 4, "post_rst");
`ifdef MAC_SEQ_RESCNT_EN
        check("res_count", {16'd0, res_count}, 32'd2);
`endif
        run_job(5'd4, 6'd0, 1'b0, 1'b0, 1'b0, 5, 8'h2C, 4, "backpr");

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/mac_8bit_seq.md
Name: mac_8bit_seq

Overview:
- Initiator-side sequencer for the 8-bit MAC math-block unit: drives the MAC operand, coefficient, clock-enable, clear, round, saturate, output-select and two's-complement controls, then captures the MAC output.
- Runs one dot-product job per command: N streamed 8-bit samples times N coefficients from a local coefficient bank.
- Returns one 8-bit result per job on a valid/ready port.
- Sits in the eFPGA math-block wrapper between fabric-side streams and the MAC accumulator.

Parameters:
- COEF_DEPTH, 16, number of coefficient entries; maximum job length.
- ADDR_W, 4, coefficient address width; equals log2(COEF_DEPTH).
- LEN_W, 5, width of the command length field.

Ports:
- MAC_ACC_CLK  in  1  clock, shared with the MAC accumulator.
- acc_ff_rstn  in  1  asynchronous active-low reset; the same reset used by the MAC accumulator.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  ADDR_W  coefficient write address.
- coef_wdata  in  8  coefficient write data.
- cmd_valid  in  1  job command valid.
- cmd_ready  out  1  command accept.
- cmd_len  in  LEN_W  number of taps.
- cmd_out_sel  in  6  accumulator output bit-select.
- cmd_rnd  in  1  round enable.
- cmd_sat  in  1  saturate enable.
- cmd_tc  in  1  signed (two's-complement) mode.
- smp_valid  in  1  sample valid.
- smp_ready  out  1  sample accept.
- smp_data  in  8  sample.
- MAC_OPER_DATA  out  8  operand to MAC.
- MAC_COEF_DATA  out  8  coefficient to MAC.
- EFPGA_MATHB_CLK_EN  out  1  accumulator load enable.
- MAC_ACC_CLEAR  out  1  accumulator clear.
- MAC_ACC_RND  out  1  round preload.
- MAC_ACC_SAT  out  1  saturate select.
- MAC_OUT_SEL  out  6  output select.
- MAC_TC  out  1  signed mode.
- MAC_OUT  in  8  MAC result.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_data  out  8  result.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: the reset is acc_ff_rstn, asynchronous and active-low; the clock is MAC_ACC_CLK. On reset every register clears: state IDLE, all MAC drive outputs 0, res_valid 0, res_data 0, coefficient bank 0, counters 0.
- Reset mid-job aborts the job. No result is produced and the state returns to IDLE.
- Coefficient bank: synchronous write on coef_we. Writes are allowed at any time. On a same-cycle write and read of one address, the read returns the old value.
- All MAC drive outputs are registered.
- States: IDLE, RUN, FLUSH, CAPT, DONE.
- IDLE:
  - cmd_ready=1.
  - On a command handshake, latch out_sel, rnd, sat and tc. These drive MAC_OUT_SEL, MAC_ACC_RND qualifier, MAC_ACC_SAT and MAC_TC and are held until the next command is accepted.
  - Length rule: len = min(cmd_len, COEF_DEPTH). Clear tap index idx.
  - cmd_len=0: go to DONE next cycle with res_data=8'h00. No sample is consumed and EFPGA_MATHB_CLK_EN is never asserted. Otherwise go to RUN.
- RUN:
  - smp_ready=1. On each sample handshake, register MAC_OPER_DATA=smp_data, MAC_COEF_DATA=coef[idx] and EFPGA_MATHB_CLK_EN=1, then increment idx.
  - For idx==0 only: MAC_ACC_CLEAR=~rnd and MAC_ACC_RND=rnd. For all later taps both are 0.
  - Cycles with no handshake register EFPGA_MATHB_CLK_EN=0, CLEAR=0, RND=0. The accumulator holds during these stalls.
  - The handshake at idx==len-1 moves the state to FLUSH.
- FLUSH: smp_ready=0. The final product is on the MAC inputs. The next edge clears EFPGA_MATHB_CLK_EN; go to CAPT.
- CAPT: MAC_OUT is valid, since the accumulator and the MAC's delayed output select are both stable. The edge loads res_data<=MAC_OUT and sets res_valid=1; go to DONE.
- DONE:
  - res_valid and res_data are held until res_ready.
  - On the result handshake, res_valid clears and the state goes to IDLE.
  - cmd_ready=0 and smp_ready=0 throughout.
- Latency: res_valid rises exactly 2 cycles after the edge that accepts the final sample.
- Arithmetic is performed entirely by the MAC. This block does no sign extension. The rounding constant is applied by the MAC from MAC_OUT_SEL.

Optional Feature:
- Macro: MAC_SEQ_RESCNT_EN.
- When defined: adds output res_count [15:0], reset 0. It increments on every res_valid && res_ready handshake and wraps 16'hFFFF -> 16'h0000.
- When undefined: the port and the counter do not exist. All other behaviour is identical.

Test Plan:
- Unsigned dot product: coef[0..3]=1,2,3,4; samples 10,20,30,40; len=4; out_sel=0; sat=0; tc=0 -> accumulator 300 (0x12C); res_data=8'h2C; res_valid exactly 2 cycles after the 4th sample handshake.
- Saturation: same job with sat=1 -> res_data=8'hFF.
- Signed: coef[0]=8'hFF; sample 8'h05; len=1; tc=1; sat=1; out_sel=0 -> res_data=8'hFB; MAC_TC=1 throughout.
- Rounding: coef[0..1]=1,1; samples 1,2; out_sel=1; rnd=1 -> res_data=8'h02. Same job with rnd=0 -> 8'h01. MAC_ACC_RND pulses only with the first tap.
- Stalls and length edge cases:
  - Same job as the first scenario with smp_valid toggling 1,0,0,1,0,1,1 -> EFPGA_MATHB_CLK_EN low in every gap; res_data=8'h2C.
  - cmd_len=0 -> res_data=8'h00 with no EFPGA_MATHB_CLK_EN pulse.
  - cmd_len=20 -> only 16 samples consumed.
- Reset and back-pressure:
  - acc_ff_rstn low after the 2nd sample -> all outputs 0, busy=0; the next job's result is correct.
  - res_ready held low for 5 cycles -> res_data stable and cmd_ready=0 until the handshake.
  - With MAC_SEQ_RESCNT_EN defined: res_count=2 after two jobs.
